card_match_fsm: RTL and testbench
=================================

// Module: card_match_fsm
// PURPOSE
// Game-play engine that consumes the 48-bit card map (16 cards x 3-bit symbol) and its one-cycle done pulse
// from the random assignment stage. Tracks player flips two cards at a time, compares symbols and marks pairs
// matched. Times the mismatch-display window and counts moves and pairs. Drives the display and win logic.
// PARAMETERS
// NUM_CARDS      16          number of cards on the board (fixed: map is 48 bits)
// SYM_W          3           symbol width per card
// IDX_W          4           card index width
// MISMATCH_HOLD  50_000_000  cycles a mismatched pair stays face-up (1 s @ 50 MHz); must be >= 1
// MOVE_W         8           width of move counter
// PORTS
// clk         in   1       system clock, rising edge
// reset       in   1       asynchronous, active-low reset
// map_in      in   48      card map; card i symbol = map_in[i*3 +: 3]
// map_load    in   1       one-cycle pulse: map_in valid, start new game
// sel_idx     in   4       card index chosen by player
// sel_valid   in   1       one-cycle pulse: sel_idx valid (already debounced/edge-detected)
// map_q       out  48      latched map for the display
// face_up     out  16      cards currently shown but not yet matched
// matched     out  16      cards permanently matched
// moves       out  MOVE_W  completed pair attempts, saturating
// pairs       out  4       matched pairs found, 0..8
// busy        out  1       1 in COMPARE and SHOW_MISMATCH (selections ignored)
// game_won    out  1       level, 1 once all 8 pairs are matched
// BEHAVIOUR
// - Reset (async, active-low): all outputs 0, state IDLE, timer 0. Reset mid-game abandons it; IDLE until next map_load.
// - States: IDLE, WAIT_FIRST, WAIT_SECOND, COMPARE, SHOW_MISMATCH, WIN. All outputs are registered.
// - map_load in ANY state, highest priority:
//   - next cycle: map_q=map_in; face_up, matched, moves, pairs and game_won cleared; state WAIT_FIRST.
//   - a sel_valid in the same cycle is dropped.
// - Selection is legal only in WAIT_FIRST/WAIT_SECOND, and only for a card with face_up[idx]=0 and matched[idx]=0.
//   Illegal or out-of-state selections are ignored: no state or output change.
// - WAIT_FIRST + legal sel: next cycle face_up[idx]=1, first=idx, state WAIT_SECOND.
// - WAIT_SECOND + legal sel: next cycle face_up[idx]=1, second=idx, state COMPARE. Picking first again is illegal.
// - COMPARE (exactly 1 cycle): moves+1, saturating at 2^MOVE_W-1. Compares map_q symbols of first and second.
//   - equal: next cycle both face_up bits cleared, both matched bits set, pairs+1.
//     - pairs reaches 8: state WIN, else WAIT_FIRST.
//   - unequal: timer=MISMATCH_HOLD-1, state SHOW_MISMATCH.
// - SHOW_MISMATCH: timer decrements each cycle. In the cycle timer==0, both face_up bits clear, state WAIT_FIRST.
//   Cards stay visible for exactly MISMATCH_HOLD cycles.
// - WIN: game_won=1, all matched bits 1. Holds until map_load or reset.
// - Latency: sel_valid -> face_up visible 1 cycle. Second sel -> matched visible 2 cycles.
// - Map is not checked for pair validity; identical symbols on >2 cards match any pair of them.
// - pairs saturates at 8; game_won is set only by the 8th match.
// STRUCTURE
// - Shared include card_flip_pkg.vh: NUM_CARDS, SYM_W, IDX_W, NUM_PAIRS=8, state encodings, map slice macro.
//   The random assignment stage and the display reuse it.
// - One sub-module hold_timer: loadable down-counter with load, value, and zero flag.
//   Width is $clog2(MISMATCH_HOLD).
// - Top holds the FSM, face_up/matched vectors, index latches and counters.
// TESTING (bench uses MISMATCH_HOLD=4)
// 1. Reset low with sel_valid toggling -> all outputs 0. After release, selections ignored until map_load.
// 2. map_in=48'h0 with sym(0)=sym(5)=3, then sel 0 and sel 5
//    -> face_up=16'h0021 -> matched=16'h0021, face_up=0, pairs=1, moves=1.
// 3. sym(1)=2, sym(2)=4; sel 1, sel 2 -> face_up=16'h0006 for exactly 4 cycles after COMPARE, then 0.
//    moves=1, pairs=0. A sel_valid during busy is ignored.
// 4. Reselect a face_up card and a matched card -> no change. Simultaneous map_load+sel_valid -> new game, select dropped.
// 5. Full solve of a valid map in 8 correct attempts -> matched=16'hFFFF, pairs=8, game_won=1, moves=8.
//    Further sels ignored. Then 300 mismatching attempts -> moves saturates at 255.
// 6. Assert reset during SHOW_MISMATCH -> outputs 0 immediately (async). No face_up clear glitch after release.

Source files
------------

// File: rtl/card_match_fsm_pkg.sv
// Shared board constants, FSM state encoding and map slicing helper for the card-flip game.
// The shuffle stage and the display logic import the same definitions.
package card_match_fsm_pkg;

    localparam int unsigned NUM_CARDS = 16;
    localparam int unsigned SYM_W     = 3;
    localparam int unsigned IDX_W     = 4;
    localparam int unsigned NUM_PAIRS = 8;
    localparam int unsigned PAIR_W    = 4;
    localparam int unsigned MAP_W     = NUM_CARDS * SYM_W;

    typedef enum logic [2:0] {
        StIdle,
        StWaitFirst,
        StWaitSecond,
        StCompare,
        StShowMismatch,
        StWin
    } state_e;

    function automatic logic [SYM_W-1:0] card_sym(input logic [MAP_W-1:0] map,
                                                  input logic [IDX_W-1:0] idx);
        return map[idx*SYM_W +: SYM_W];
    endfunction

endpackage

// File: rtl/card_match_fsm_hold_timer.sv
// Loadable down-counter that stops at zero; zero_o flags the final cycle of a hold window.
module card_match_fsm_hold_timer #(
    parameter int unsigned Width = 26
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] value_i,
    output logic             zero_o
);

    logic [Width-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/card_match_fsm.sv
// Game-play engine: tracks two-card flips, compares symbols, marks matches, times the
// mismatch display window and counts moves and pairs.
module card_match_fsm
    import card_match_fsm_pkg::*;
#(
    parameter int unsigned MismatchHold = 50_000_000,
    parameter int unsigned MoveW        = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [MAP_W-1:0]     map_in_i,
    input  logic                 map_load_i,
    input  logic [IDX_W-1:0]     sel_idx_i,
    input  logic                 sel_valid_i,
    output logic [MAP_W-1:0]     map_q_o,
    output logic [NUM_CARDS-1:0] face_up_o,
    output logic [NUM_CARDS-1:0] matched_o,
    output logic [MoveW-1:0]     moves_o,
    output logic [PAIR_W-1:0]    pairs_o,
    output logic                 busy_o,
    output logic                 game_won_o
);

    // Guard against a zero-width counter when the hold is a single cycle.
    localparam int unsigned TimerW = (MismatchHold > 1) ? $clog2(MismatchHold) : 1;

    state_e               state_d, state_q;
    logic [MAP_W-1:0]     map_d, map_q;
    logic [NUM_CARDS-1:0] face_up_d, face_up_q;
    logic [NUM_CARDS-1:0] matched_d, matched_q;
    logic [IDX_W-1:0]     first_d, first_q;
    logic [IDX_W-1:0]     second_d, second_q;
    logic [MoveW-1:0]     moves_d, moves_q;
    logic [PAIR_W-1:0]    pairs_d, pairs_q;
    logic                 busy_d, busy_q;
    logic                 won_d, won_q;
    logic                 timer_load;
    logic                 timer_zero;
    logic                 sel_ok;

    card_match_fsm_hold_timer #(
        .Width (TimerW)
    ) u_hold_timer (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (timer_load),
        .value_i (TimerW'(MismatchHold - 1)),
        .zero_o  (timer_zero)
    );

    assign sel_ok = sel_valid_i && !face_up_q[sel_idx_i] && !matched_q[sel_idx_i];

    always_comb begin
        state_d    = state_q;
        map_d      = map_q;
        face_up_d  = face_up_q;
        matched_d  = matched_q;
        first_d    = first_q;
        second_d   = second_q;
        moves_d    = moves_q;
        pairs_d    = pairs_q;
        won_d      = won_q;
        timer_load = 1'b0;

        if (map_load_i) begin
            // New game wins over everything, including a coincident selection.
            map_d     = map_in_i;
            face_up_d = '0;
            matched_d = '0;
            moves_d   = '0;
            pairs_d   = '0;
            won_d     = 1'b0;
            state_d   = StWaitFirst;
        end else begin
            unique case (state_q)
                StIdle: ;
                StWaitFirst: begin
                    if (sel_ok) begin
                        face_up_d[sel_idx_i] = 1'b1;
                        first_d              = sel_idx_i;
                        state_d              = StWaitSecond;
                    end
                end
                StWaitSecond: begin
                    if (sel_ok) begin
                        face_up_d[sel_idx_i] = 1'b1;
                        second_d             = sel_idx_i;
                        state_d              = StCompare;
                    end
                end
                StCompare: begin
                    moves_d = (moves_q == {MoveW{1'b1}}) ? moves_q : moves_q + 1'b1;
                    if (card_sym(map_q, first_q) == card_sym(map_q, second_q)) begin
                        face_up_d[first_q]  = 1'b0;
                        face_up_d[second_q] = 1'b0;
                        matched_d[first_q]  = 1'b1;
                        matched_d[second_q] = 1'b1;
                        pairs_d = (pairs_q == PAIR_W'(NUM_PAIRS)) ? pairs_q : pairs_q + 1'b1;
                        if (pairs_q == PAIR_W'(NUM_PAIRS - 1)) begin
                            won_d   = 1'b1;
                            state_d = StWin;
                        end else begin
                            state_d = StWaitFirst;
                        end
                    end else begin
                        timer_load = 1'b1;
                        state_d    = StShowMismatch;
                    end
                end
                StShowMismatch: begin
                    if (timer_zero) begin
                        face_up_d[first_q]  = 1'b0;
                        face_up_d[second_q] = 1'b0;
                        state_d             = StWaitFirst;
                    end
                end
                StWin: begin
                    matched_d = '1;
                    won_d     = 1'b1;
                end
                default: state_d = StIdle;
            endcase
        end

        busy_d = (state_d == StCompare) || (state_d == StShowMismatch);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            map_q     <= '0;
            face_up_q <= '0;
            matched_q <= '0;
            first_q   <= '0;
            second_q  <= '0;
            moves_q   <= '0;
            pairs_q   <= '0;
            busy_q    <= 1'b0;
            won_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            map_q     <= map_d;
            face_up_q <= face_up_d;
            matched_q <= matched_d;
            first_q   <= first_d;
            second_q  <= second_d;
            moves_q   <= moves_d;
            pairs_q   <= pairs_d;
            busy_q    <= busy_d;
            won_q     <= won_d;
        end
    end

    assign map_q_o    = map_q;
    assign face_up_o  = face_up_q;
    assign matched_o  = matched_q;
    assign moves_o    = moves_q;
    assign pairs_o    = pairs_q;
    assign busy_o     = busy_q;
    assign game_won_o = won_q;

endmodule

// File: tb/tb_card_match_fsm.sv
// Scenario bench for card_match_fsm: expected output snapshots are queued at stimulus time
// and popped for comparison once the DUT has had its cycle(s) to respond.
module tb_card_match_fsm;

    localparam int unsigned Hold = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [47:0] map_in_i;
    logic        map_load_i;
    logic [3:0]  sel_idx_i;
    logic        sel_valid_i;
    logic [47:0] map_q_o;
    logic [15:0] face_up_o;
    logic [15:0] matched_o;
    logic [7:0]  moves_o;
    logic [3:0]  pairs_o;
    logic        busy_o;
    logic        game_won_o;

    typedef struct {
        string       name;
        logic [45:0] v;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk_i = ~clk_i;

    card_match_fsm #(
        .MismatchHold (Hold),
        .MoveW        (8)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .map_in_i    (map_in_i),
        .map_load_i  (map_load_i),
        .sel_idx_i   (sel_idx_i),
        .sel_valid_i (sel_valid_i),
        .map_q_o     (map_q_o),
        .face_up_o   (face_up_o),
        .matched_o   (matched_o),
        .moves_o     (moves_o),
        .pairs_o     (pairs_o),
        .busy_o      (busy_o),
        .game_won_o  (game_won_o)
    );

    // Snapshot layout: {face_up, matched, moves, pairs, busy, game_won}
    function automatic logic [45:0] obs();
        return {face_up_o, matched_o, moves_o, pairs_o, busy_o, game_won_o};
    endfunction

    function automatic logic [45:0] ex(input logic [15:0] f, input logic [15:0] m,
                                       input logic [7:0] mv, input logic [3:0] p,
                                       input logic b, input logic w);
        return {f, m, mv, p, b, w};
    endfunction

    function automatic logic [47:0] small_map();
        logic [47:0] m;
        m = '0;
        m[0 +: 3]  = 3'd3;
        m[3 +: 3]  = 3'd2;
        m[6 +: 3]  = 3'd4;
        m[15 +: 3] = 3'd3;
        return m;
    endfunction

    function automatic logic [47:0] solve_map();
        logic [47:0] m;
        m = '0;
        for (int i = 0; i < 16; i++) m[i*3 +: 3] = 3'(i / 2);
        return m;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pick(input logic [3:0] idx);
        sel_idx_i   = idx;
        sel_valid_i = 1'b1;
        tick();
        sel_valid_i = 1'b0;
    endtask

    task automatic load(input logic [47:0] m);
        map_in_i   = m;
        map_load_i = 1'b1;
        tick();
        map_load_i = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_ni = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sel_idx_i   = 4'(i);
            sel_valid_i = (i % 2) == 0;
            tick();
        end
        sel_valid_i = 1'b0;
        sb_q.push_back('{"reset_outputs", ex(0, 0, 0, 0, 0, 0)});
        e = sb_q.pop_front();
        checks++;
        if (obs() !== e.v) begin
            failures++;
            $display("FAIL %s: got %h want %h", e.name, obs(), e.v);
        end
        checks++;
        if (map_q_o !== 48'h0) begin
            failures++;
            $display("FAIL reset_map_q: got %h want 0", map_q_o);
        end
        rst_ni = 1'b1;
        tick();
        sb_q.push_back('{"idle_sel_ignored", ex(0, 0, 0, 0, 0, 0)});
        pick(4'd3);
        e = sb_q.pop_front();
        checks++;
        if (obs() !== e.v) begin
            failures++;
            $display("FAIL %s: got %h want %h", e.name, obs(), e.v);
        end
    endtask

    task automatic test_match();
        exp_t e;
        load(small_map());
        checks++;
        if (map_q_o !== small_map()) begin
            failures++;
            $display("FAIL match_map_q: got %h want %h", map_q_o, small_map());
        end
        sb_q.push_back('{"match_first", ex(16'h0001, 0, 0, 0, 0, 0)});
        pick(4'd0);
        e = sb_q.pop_front();
        checks++;
        if (obs() !== e.v) begin
            failures++;
            $display("FAIL %s: got %h want %h", e.name, obs(), e.v);
        end
        sb_q.push_back('{"match_second", ex(16'h0021, 0, 0, 0, 1, 0)});
        pick(4'd5);
        e = sb_q.pop_front();
        checks++;
        if (obs() !== e.v) begin
            failures++;
            $display("FAIL %s: got %h want %h", e.name, obs(), e.v);
        end
        sb_q.push_back('{"match_result", ex(0, 16'h0021, 1, 1, 0, 0)});
        tick();
        e = sb_q.pop_front();
        checks++;
        if (obs() !== e.v) begin
            failures++;
            $display("FAIL %s: got %h want %h", e.name, obs(), e.v);
        end
    endtask

    task automatic test_mismatch();
        exp_t e;
        int   shown;
        load(small_map());
        pick(4'd1);
        sb_q.push_back('{"mismatch_compare", ex(16'h0006, 0, 0, 0, 1, 0)});
        pick(4'd2);
        e = sb_q.pop_front();
        checks++;
        if (obs() !== e.v) begin
            failures++;
            $display("FAIL %s: got %h want %h", e.name, obs(), e.v);
        end
        shown = 0;
        for (int i = 0; i < 12 && face_up_o != 16'h0; i++) begin
            if (i == 1) begin
                sel_idx_i   = 4'd3;
                sel_valid_i = 1'b1;
            end
            tick();
            sel_valid_i = 1'b0;
            if (face_up_o == 16'h0006) shown++;
        end
        checks++;
        if (shown !== Hold) begin
            failures++;
            $display("FAIL mismatch_hold_cycles: got %0d want %0d", shown, Hold);
        end
        sb_q.push_back('{"mismatch_after", ex(0, 0, 1, 0, 0, 0)});
        e = sb_q.pop_front();
        checks++;
        if (obs() !== e.v) begin
            failures++;
            $display("FAIL %s: got %h want %h", e.name, obs(), e.v);
        end
    endtask

    task automatic test_illegal();
        exp_t e;
        pick(4'd0);
        pick(4'd5);
        tick();
        sb_q.push_back('{"illegal_matched", ex(0, 16'h0021, 2, 1, 0, 0)});
        pick(4'd0);
        e = sb_q.pop_front();
        checks++;
        if (obs() !== e.v) begin
            failures++;
            $display("FAIL %s: got %h want %h", e.name, obs(), e.v);
        end
        pick(4'd3);
        sb_q.push_back('{"illegal_faceup", ex(16'h0008, 16'h0021, 2, 1, 0, 0)});
        pick(4'd3);
        e = sb_q.pop_front();
        checks++;
        if (obs() !== e.v) begin
            failures++;
            $display("FAIL %s: got %h want %h", e.name, obs(), e.v);
        end
        sb_q.push_back('{"illegal_matched_second", ex(16'h0008, 16'h0021, 2, 1, 0, 0)});
        pick(4'd5);
        e = sb_q.pop_front();
        checks++;
        if (obs() !== e.v) begin
            failures++;
            $display("FAIL %s: got %h want %h", e.name, obs(), e.v);
        end
        map_in_i    = solve_map();
        map_load_i  = 1'b1;
        sel_idx_i   = 4'd4;
        sel_valid_i = 1'b1;
        sb_q.push_back('{"load_drops_sel", ex(0, 0, 0, 0, 0, 0)});
        tick();
        map_load_i  = 1'b0;
        sel_valid_i = 1'b0;
        e = sb_q.pop_front();
        checks++;
        if (obs() !== e.v || map_q_o !== solve_map()) begin
            failures++;
            $display("FAIL %s: got %h map %h want %h map %h", e.name, obs(), map_q_o, e.v,
                     solve_map());
        end
        sb_q.push_back('{"load_then_first", ex(16'h0010, 0, 0, 0, 0, 0)});
        pick(4'd4);
        e = sb_q.pop_front();
        checks++;
        if (obs() !== e.v) begin
            failures++;
            $display("FAIL %s: got %h want %h", e.name, obs(), e.v);
        end
    endtask

    task automatic test_full_solve();
        exp_t        e;
        logic [31:0] mask;
        int          wait_cnt;
        load(solve_map());
        for (int k = 0; k < 8; k++) begin
            mask = (32'h1 << (2 * k + 2)) - 32'h1;
            sb_q.push_back('{$sformatf("solve_pair%0d", k),
                             ex(0, mask[15:0], 8'(k + 1), 4'(k + 1), 0, k == 7)});
            pick(4'(2 * k));
            pick(4'(2 * k + 1));
            tick();
            e = sb_q.pop_front();
            checks++;
            if (obs() !== e.v) begin
                failures++;
                $display("FAIL %s: got %h want %h", e.name, obs(), e.v);
            end
        end
        sb_q.push_back('{"win_sel_ignored", ex(0, 16'hFFFF, 8, 8, 0, 1)});
        pick(4'd3);
        tick();
        e = sb_q.pop_front();
        checks++;
        if (obs() !== e.v) begin
            failures++;
            $display("FAIL %s: got %h want %h", e.name, obs(), e.v);
        end
        load(solve_map());
        sb_q.push_back('{"moves_saturate", ex(0, 0, 255, 0, 0, 0)});
        for (int a = 0; a < 300; a++) begin
            pick(4'd0);
            pick(4'd2);
            wait_cnt = 0;
            while (busy_o && wait_cnt < 20) begin
                tick();
                wait_cnt++;
            end
            if (wait_cnt >= 20) begin
                checks++;
                failures++;
                $display("FAIL busy_timeout: busy still %b after %0d cycles, want 0", busy_o,
                         wait_cnt);
                break;
            end
        end
        e = sb_q.pop_front();
        checks++;
        if (obs() !== e.v) begin
            failures++;
            $display("FAIL %s: got %h want %h", e.name, obs(), e.v);
        end
    endtask

    task automatic test_reset_in_show();
        exp_t e;
        int   glitches;
        load(solve_map());
        pick(4'd0);
        pick(4'd2);
        tick();
        #2;
        sb_q.push_back('{"async_reset", ex(0, 0, 0, 0, 0, 0)});
        rst_ni = 1'b0;
        #1;
        e = sb_q.pop_front();
        checks++;
        if (obs() !== e.v || map_q_o !== 48'h0) begin
            failures++;
            $display("FAIL %s: got %h map %h want %h map 0", e.name, obs(), map_q_o, e.v);
        end
        tick();
        rst_ni   = 1'b1;
        glitches = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (obs() !== 46'h0) glitches++;
        end
        checks++;
        if (glitches !== 0) begin
            failures++;
            $display("FAIL post_reset_glitch: got %0d nonzero cycles want 0", glitches);
        end
        sb_q.push_back('{"post_reset_idle", ex(0, 0, 0, 0, 0, 0)});
        pick(4'd1);
        e = sb_q.pop_front();
        checks++;
        if (obs() !== e.v) begin
            failures++;
            $display("FAIL %s: got %h want %h", e.name, obs(), e.v);
        end
    endtask

    initial begin
        rst_ni      = 1'b0;
        map_in_i    = '0;
        map_load_i  = 1'b0;
        sel_idx_i   = '0;
        sel_valid_i = 1'b0;
        test_reset();
        test_match();
        test_mismatch();
        test_illegal();
        test_full_solve();
        test_reset_in_show();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
